dm_port_arbiter: RTL and testbench

DM_PORT_ARBITER -- requirements
Module: dm_port_arbiter

---
 rtl/dm_port_arbiter.sv | 103 ++++++++++
 tb/tb_dm_port_arbiter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/dm_port_arbiter.sv
// rtl/dm_port_arbiter.sv - two-requester (CPU/debug) data-memory port arbiter with bounded bursts
module dm_port_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, CPU, DBG} owner_t;

  localparam logic [4:0] BURST_LIM = 5'(MAX_BURST);

  owner_t      owner, owner_nxt;
  logic        last_dbg;
  logic [3:0]  burst_cnt, burst_nxt;
  logic        burst_full;
  logic        cpu_acc, dbg_acc;

  assign cpu_gnt   = (owner == CPU);
  assign dbg_gnt   = (owner == DBG);
  assign cpu_acc   = cpu_gnt && cpu_req;
  assign dbg_acc   = dbg_gnt && dbg_req;
  assign cpu_stall = cpu_req && !cpu_gnt;

  assign mem_en    = cpu_acc || dbg_acc;
  assign mem_we    = (cpu_acc && cpu_we) || (dbg_acc && dbg_we);
  assign mem_addr  = dbg_acc ? dbg_addr  : cpu_addr;
  assign mem_wdata = dbg_acc ? dbg_wdata : cpu_wdata;

  // Read data is only meaningful in the return cycle; zero it otherwise.
  assign cpu_rdata = cpu_rvalid ? mem_rdata : '0;
  assign dbg_rdata = dbg_rvalid ? mem_rdata : '0;

  // True when the transfer accepted this cycle completes the owner's burst quota.
  assign burst_full = ({1'b0, burst_cnt} + 5'd1) >= BURST_LIM;

  always_comb begin
    owner_nxt = owner;
    burst_nxt = burst_cnt;
    case (owner)
      IDLE: begin
        if (cpu_req && (!dbg_req || last_dbg)) owner_nxt = CPU;
        else if (dbg_req)                      owner_nxt = DBG;
      end
      CPU: begin
        if (cpu_req) begin
          if (dbg_req && burst_full) owner_nxt = DBG;
        end else begin
          owner_nxt = dbg_req ? DBG : IDLE;
        end
      end
      DBG: begin
        if (dbg_req) begin
          if (cpu_req && burst_full) owner_nxt = CPU;
        end else begin
          owner_nxt = cpu_req ? CPU : IDLE;
        end
      end
      default: owner_nxt = IDLE;
    endcase
    if (owner_nxt != owner)                    burst_nxt = 4'd0;
    else if ((cpu_acc || dbg_acc) && !burst_full) burst_nxt = burst_cnt + 4'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner      <= IDLE;
      last_dbg   <= 1'b1;
      burst_cnt  <= 4'd0;
      cpu_rvalid <= 1'b0;
      dbg_rvalid <= 1'b0;
    end else begin
      owner      <= owner_nxt;
      burst_cnt  <= burst_nxt;
      cpu_rvalid <= cpu_acc && !cpu_we;
      dbg_rvalid <= dbg_acc && !dbg_we;
      if (owner != IDLE && owner_nxt != owner) last_dbg <= (owner == DBG);
    end
  end

endmodule

// File: tb/tb_dm_port_arbiter.sv
// tb/tb_dm_port_arbiter.sv - randomized and directed self-checking bench for dm_port_arbiter
module tb_dm_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MB = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cpu_req = 1'b0, cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic          cpu_gnt, cpu_rvalid, cpu_stall;
  logic [DW-1:0] cpu_rdata;
  logic          dbg_req = 1'b0, dbg_we = 1'b0;
  logic [AW-1:0] dbg_addr = '0;
  logic [DW-1:0] dbg_wdata = '0;
  logic          dbg_gnt, dbg_rvalid;
  logic [DW-1:0] dbg_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dm_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // Synchronous-read data memory seen by the DUT.
  logic [DW-1:0] tmem [16];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) tmem[mem_addr[5:2]] <= mem_wdata;
      else        mem_rdata <= tmem[mem_addr[5:2]];
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: owner 0=none 1=cpu 2=dbg, run = accepts in current tenure (unbounded).
  int            m_owner = 0, m_last = 2, m_run = 0, m_nx;
  bit            m_rv_c = 0, m_rv_d = 0;
  logic [DW-1:0] m_rd_c = '0, m_rd_d = '0;
  logic [DW-1:0] mmem [16];
  logic          m_acc_c, m_acc_d;

  function automatic int next_owner(int own, int last, int run, bit cr, bit dr);
    bit mine, theirs;
    if (own == 0) return (cr && dr) ? ((last == 2) ? 1 : 2) : (cr ? 1 : (dr ? 2 : 0));
    mine   = (own == 1) ? cr : dr;
    theirs = (own == 1) ? dr : cr;
    if (mine) return (theirs && run + 1 >= MB) ? 3 - own : own;
    return theirs ? 3 - own : 0;
  endfunction

  always_comb begin
    m_acc_c = (m_owner == 1) && cpu_req;
    m_acc_d = (m_owner == 2) && dbg_req;
    m_nx    = next_owner(m_owner, m_last, m_run, cpu_req, dbg_req);
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_owner <= 0; m_last <= 2; m_run <= 0; m_rv_c <= 0; m_rv_d <= 0;
    end else begin
      m_rv_c <= m_acc_c && !cpu_we;
      m_rv_d <= m_acc_d && !dbg_we;
      if (m_acc_c && !cpu_we) m_rd_c <= mmem[cpu_addr[5:2]];
      if (m_acc_d && !dbg_we) m_rd_d <= mmem[dbg_addr[5:2]];
      if (m_acc_c && cpu_we)  mmem[cpu_addr[5:2]] <= cpu_wdata;
      if (m_acc_d && dbg_we)  mmem[dbg_addr[5:2]] <= dbg_wdata;
      if (m_nx != m_owner) begin
        m_run <= 0;
        if (m_owner != 0) m_last <= m_owner;
      end else if (m_acc_c || m_acc_d) begin
        m_run <= m_run + 1;
      end
      m_owner <= m_nx;
    end
  end

  always @(negedge clk) begin
    chk("cpu_gnt", cpu_gnt, m_owner == 1);
    chk("dbg_gnt", dbg_gnt, m_owner == 2);
    chk("cpu_stall", cpu_stall, cpu_req && m_owner != 1);
    chk("mem_en", mem_en, m_acc_c || m_acc_d);
    chk("mem_we", mem_we, (m_acc_c && cpu_we) || (m_acc_d && dbg_we));
    if (m_acc_c || m_acc_d) chk("mem_addr", mem_addr, m_acc_c ? cpu_addr : dbg_addr);
    if ((m_acc_c && cpu_we) || (m_acc_d && dbg_we)) chk("mem_wdata", mem_wdata, m_acc_c ? cpu_wdata : dbg_wdata);
    chk("cpu_rvalid", cpu_rvalid, m_rv_c);
    chk("dbg_rvalid", dbg_rvalid, m_rv_d);
    if (m_rv_c || !rst_n) chk("cpu_rdata", cpu_rdata, m_rv_c ? m_rd_c : '0);
    if (m_rv_d || !rst_n) chk("dbg_rdata", dbg_rdata, m_rv_d ? m_rd_d : '0);
  end

  // Raise a request and return at the negedge of its accepting cycle.
  task automatic xfer(input bit d, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] w);
    if (d) begin dbg_req = 1; dbg_we = we; dbg_addr = a; dbg_wdata = w; end
    else   begin cpu_req = 1; cpu_we = we; cpu_addr = a; cpu_wdata = w; end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (d ? dbg_gnt : cpu_gnt) break;
    end
    chk(d ? "xfer_dbg_gnt" : "xfer_cpu_gnt", d ? dbg_gnt : cpu_gnt, 1);
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst_n = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
  endtask

  initial begin
    bit acc_c, acc_d;
    int p;
    for (int i = 0; i < 16; i++) begin
      tmem[i] <= 32'hA5A50000 ^ (i * 32'h01010101);
      mmem[i] <= 32'hA5A50000 ^ (i * 32'h01010101);
    end
    tmem[4] <= 32'hDEADBEEF;
    mmem[4] <= 32'hDEADBEEF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_gnt", {cpu_gnt, dbg_gnt, mem_en, mem_we, cpu_rvalid, dbg_rvalid}, 6'b0);

    // Single CPU read of 0x10
    @(posedge clk); #1 rst_n = 1; cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10;
    @(negedge clk); chk("r029_c1_gnt", cpu_gnt, 0); chk("r029_c1_stall", cpu_stall, 1);
    @(posedge clk); #1;
    @(negedge clk); chk("r029_c2_gnt", cpu_gnt, 1); chk("r029_c2_addr", mem_addr, 32'h10);
    @(posedge clk); #1 cpu_req = 0;
    @(negedge clk); chk("r029_c3_rv", cpu_rvalid, 1); chk("r029_c3_rd", cpu_rdata, 32'hDEADBEEF);

    // Debug write then CPU read-back
    @(posedge clk); #1;
    xfer(1, 1, 32'h20, 32'h55);
    chk("r031_we", mem_we, 1); chk("r031_wd", mem_wdata, 32'h55);
    @(posedge clk); #1 dbg_req = 0; dbg_we = 0;
    @(negedge clk); chk("r031_dbg_rv", dbg_rvalid, 0);
    @(posedge clk); #1;
    xfer(0, 0, 32'h20, 0);
    @(posedge clk); #1 cpu_req = 0;
    @(negedge clk); chk("r031_rv", cpu_rvalid, 1); chk("r031_rd", cpu_rdata, 32'h55);

    // CPU alone, 10 back-to-back reads
    @(posedge clk); #1;
    xfer(0, 0, 32'h0, 0);
    for (int k = 0; k <= 10; k++) begin
      if (k > 0) @(negedge clk);
      if (k < 10) chk("r032_gnt", cpu_gnt, 1);
      if (k >= 1) chk("r032_rv", cpu_rvalid, 1);
      if (k == 9) chk("r032_burst", dut.burst_cnt, 4'd3);
      @(posedge clk); #1;
      if (k == 9) cpu_req = 0; else cpu_addr = cpu_addr + 32'h4;
    end

    // Both requesting from reset: 4/4 alternation, no bubbles
    @(posedge clk); #1 rst_n = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1; cpu_req = 1; cpu_we = 0; cpu_addr = 32'h8; dbg_req = 1; dbg_we = 0; dbg_addr = 32'hC;
    for (int c = 1; c <= 17; c++) begin
      bit ec, ed;
      @(negedge clk);
      ec = (c >= 2) && (((c - 2) / 4) % 2 == 0);
      ed = (c >= 2) && (((c - 2) / 4) % 2 == 1);
      chk("r030_cgnt", cpu_gnt, ec);
      chk("r030_dgnt", dbg_gnt, ed);
      chk("r030_stall", cpu_stall, !ec);
      if (c == 6) chk("r034_rv_at_switch", cpu_rvalid, 1);
      @(posedge clk); #1;
    end
    cpu_req = 0; dbg_req = 0;
    repeat (2) @(posedge clk);

    // Reset during the accepting cycle of a CPU read
    #1;
    xfer(0, 0, 32'h14, 0);
    #1 rst_n = 0;
    @(posedge clk); #1 cpu_req = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("r033_rv", cpu_rvalid, 0);
      chk("r033_gnt", cpu_gnt, 0);
      @(posedge clk); #1;
      if (k == 2) rst_n = 1;
    end

    // Randomized traffic
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      acc_c = cpu_req && cpu_gnt;
      acc_d = dbg_req && dbg_gnt;
      @(posedge clk); #1;
      p = (cyc < 1500) ? 85 : (cyc < 3000) ? 30 : 60;
      if (cyc == 2500) begin rst_n = 0; acc_c = 1; acc_d = 1; end
      if (cyc == 2502) rst_n = 1;
      if (acc_c || !cpu_req) begin
        cpu_req = ($urandom_range(99) < p);
        cpu_we = $urandom_range(1); cpu_addr = {26'h0, 4'($urandom), 2'b00}; cpu_wdata = $urandom;
      end
      if (acc_d || !dbg_req) begin
        dbg_req = ($urandom_range(99) < p);
        dbg_we = $urandom_range(1); dbg_addr = {26'h0, 4'($urandom), 2'b00}; dbg_wdata = $urandom;
      end
    end
    cpu_req = 0; dbg_req = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
